video_mnist_cnn_unit: RTL and testbench

Streaming binary classifier for the MNIST video path. It sits between the camera AXI4-Stream source and the colouring stage. Each 8-bit grey pixel is binarized against a threshold, and the frame is tiled into 4x4 blocks. Each block is matched against ten Wishbone-programmable 4x4 binary kernels (one-layer binary convolution), and one result per block is emitted, giving a (X/4)x(Y/4) output stream of class number, confidence and per-class scores.

---
 rtl/video_mnist_cnn_unit.sv | 176 +++++++++++++++++
 tb/tb_video_mnist_cnn_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_cnn_unit.sv
// rtl/video_mnist_cnn_unit.sv - 4x4 binary-kernel block classifier on a pixel stream.
// Wishbone readback is present only when VIDEO_MNIST_CNN_WB_READBACK_EN is defined.
module video_mnist_cnn_unit #(
    parameter int IMG_X_NUM      = 640,
    parameter int IMG_Y_NUM      = 480,
    parameter int IMG_Y_WIDTH    = 12,
    parameter int TUSER_WIDTH    = 1,
    parameter int S_TDATA_WIDTH  = 8,
    parameter int WB_ADR_WIDTH   = 8,
    parameter int WB_DAT_WIDTH   = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int INIT_PARAM_TH  = 127,
    parameter int INIT_PARAM_INV = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [3:0]               m_axi4s_tnumber,
    output logic [3:0]               m_axi4s_tcount,
    output logic [79:0]              m_axi4s_tclustering,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,
    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic                     s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o
);
    localparam int XB  = IMG_X_NUM / 4;
    localparam int XBW = (XB > 1) ? $clog2(XB) : 1;
    localparam logic [IMG_Y_WIDTH-1:0] X_LIM = IMG_Y_WIDTH'(IMG_X_NUM);
    localparam logic [IMG_Y_WIDTH-1:0] Y_LIM = IMG_Y_WIDTH'(IMG_Y_NUM);

    logic [7:0]  th;
    logic        inv;
    logic [15:0] kernel [10];
    logic [15:0] pat_mem [XB];

    logic [IMG_Y_WIDTH-1:0] x, y, cx, cy;
    logic                   synced;
    logic [XBW-1:0]         bx;
    logic [3:0]             bit_idx;
    logic                   accept, active, complete, pix_bit;
    logic [15:0]            base, pat_next;

    logic [4:0]  sc, best_score;
    logic [3:0]  best_num;
    logic [79:0] clus;

    logic [3:0] kidx;
    logic       kern_hit, wb_wr;
    logic       unused;

    assign s_wb_ack_o     = s_wb_stb_i;
    assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
    assign accept         = s_axi4s_tvalid && s_axi4s_tready;

    // A frame-start pixel lands at (0,0) regardless of where the counters drifted.
    assign cx      = s_axi4s_tuser[0] ? '0 : x;
    assign cy      = s_axi4s_tuser[0] ? '0 : y;
    assign bx      = cx[XBW+1:2];
    assign bit_idx = {cy[1:0], cx[1:0]};
    assign pix_bit = (s_axi4s_tdata > th) ^ inv;

    // Until a frame start is seen after reset the counters mean nothing, so stay idle.
    assign active   = accept && (synced || s_axi4s_tuser[0]) && (cx < X_LIM) && (cy < Y_LIM);
    assign complete = active && (bit_idx == 4'hF);
    assign base     = (bit_idx == 4'h0) ? 16'h0 : pat_mem[bx];
    assign pat_next = base | (16'(pix_bit) << bit_idx);

    always_comb begin
        sc         = '0;
        best_score = '0;
        best_num   = '0;
        clus       = '0;
        for (int k = 0; k < 10; k++) begin
            sc = 5'd16 - 5'($countones(pat_next ^ kernel[k]));
            clus[k*8 +: 8] = {3'b000, sc};
            if (sc > best_score) begin
                best_score = sc;
                best_num   = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            synced <= 1'b0;
        end else if (accept) begin
            if (s_axi4s_tuser[0])
                synced <= 1'b1;
            if (s_axi4s_tlast) begin
                x <= '0;
                y <= cy + IMG_Y_WIDTH'(1);
            end else begin
                x <= cx + IMG_Y_WIDTH'(1);
                y <= cy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (active)
            pat_mem[bx] <= pat_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi4s_tvalid      <= 1'b0;
            m_axi4s_tuser       <= '0;
            m_axi4s_tlast       <= 1'b0;
            m_axi4s_tnumber     <= '0;
            m_axi4s_tcount      <= '0;
            m_axi4s_tclustering <= '0;
        end else if (complete) begin
            m_axi4s_tvalid      <= 1'b1;
            m_axi4s_tuser       <= TUSER_WIDTH'(bx == '0 && cy[IMG_Y_WIDTH-1:2] == '0);
            m_axi4s_tlast       <= s_axi4s_tlast;
            m_axi4s_tnumber     <= best_num;
            m_axi4s_tcount      <= (best_score > 5'd15) ? 4'd15 : best_score[3:0];
            m_axi4s_tclustering <= clus;
        end else if (m_axi4s_tready) begin
            m_axi4s_tvalid <= 1'b0;
        end
    end

    assign wb_wr    = s_wb_stb_i && s_wb_we_i;
    assign kidx     = s_wb_adr_i[3:0];
    assign kern_hit = ((s_wb_adr_i >> 4) == WB_ADR_WIDTH'(1)) && (kidx < 4'd10);

    always_ff @(posedge clk) begin
        if (reset) begin
            th  <= 8'(INIT_PARAM_TH);
            inv <= 1'(INIT_PARAM_INV);
            for (int k = 0; k < 10; k++)
                kernel[k] <= '0;
        end else if (wb_wr) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(0) && s_wb_sel_i[0])
                th <= s_wb_dat_i[7:0];
            if (s_wb_adr_i == WB_ADR_WIDTH'(1) && s_wb_sel_i[0])
                inv <= s_wb_dat_i[0];
            if (kern_hit && s_wb_sel_i[0])
                kernel[kidx][7:0] <= s_wb_dat_i[7:0];
            if (kern_hit && s_wb_sel_i[1])
                kernel[kidx][15:8] <= s_wb_dat_i[15:8];
        end
    end

`ifdef VIDEO_MNIST_CNN_WB_READBACK_EN
    logic [WB_DAT_WIDTH-1:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (s_wb_adr_i == WB_ADR_WIDTH'(0))
            rd_data[7:0] = th;
        else if (s_wb_adr_i == WB_ADR_WIDTH'(1))
            rd_data[0] = inv;
        else if (kern_hit)
            rd_data[15:0] = kernel[kidx];
    end
    assign s_wb_dat_o = reset ? '0 : rd_data;
`else
    assign s_wb_dat_o = '0;
`endif

    assign unused = ^{s_axi4s_tuser, s_wb_dat_i[WB_DAT_WIDTH-1:16], s_wb_sel_i[WB_SEL_WIDTH-1:2]};
endmodule

// File: tb/tb_video_mnist_cnn_unit.sv
// tb/tb_video_mnist_cnn_unit.sv - randomized bench for video_mnist_cnn_unit against a block model.
module tb_video_mnist_cnn_unit;
    localparam int X  = 32;
    localparam int Y  = 16;
    localparam int XB = X / 4;
    localparam int YB = Y / 4;
`ifdef VIDEO_MNIST_CNN_WB_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct packed {
        logic        user;
        logic        last;
        logic [3:0]  num;
        logic [3:0]  cnt;
        logic [79:0] clus;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [0:0]  m_tuser;
    logic        m_tlast;
    logic [3:0]  m_tnumber, m_tcount;
    logic [79:0] m_tclus;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    bit bp_hold = 1'b0;

    logic [7:0]  m_th = 8'd127;
    logic        m_inv = 1'b0;
    logic [15:0] m_kern [10];
    int          pix [X*Y];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    video_mnist_cnn_unit #(.IMG_X_NUM(X), .IMG_Y_NUM(Y)) dut (
        .clk(clk), .reset(reset),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
        .m_axi4s_tcount(m_tcount), .m_axi4s_tclustering(m_tclus),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .s_wb_adr_i(wb_adr), .s_wb_dat_i(wb_dat), .s_wb_dat_o(wb_dat_o),
        .s_wb_we_i(wb_we), .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_block(input int by, input int bx);
        exp_t e;
        logic [15:0] p;
        int sc, best, bn;
        p = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                p[r*4+c] = (pix[(by*4+r)*X + bx*4+c] > int'(m_th)) ^ m_inv;
        e = '0;
        best = -1;
        bn = 0;
        for (int k = 0; k < 10; k++) begin
            sc = 16 - $countones(p ^ m_kern[k]);
            e.clus[k*8 +: 8] = 8'(sc);
            if (sc > best) begin
                best = sc;
                bn = k;
            end
        end
        e.num  = 4'(bn);
        e.cnt  = (best > 15) ? 4'd15 : 4'(best);
        e.user = (bx == 0 && by == 0);
        e.last = (bx == XB-1);
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    exp_t mon_e;
    bit   stalled_prev = 1'b0;
    logic [9:0]  held_ctl;
    logic [79:0] held_clus;
    always @(negedge clk) begin
        if (!reset) begin
            if (stalled_prev) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_ctl", {m_tuser, m_tlast, m_tnumber, m_tcount}, held_ctl);
                check("hold_clus", m_tclus, held_clus);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tnumber", m_tnumber, mon_e.num);
                    check("tcount", m_tcount, mon_e.cnt);
                    check("tclustering", m_tclus, mon_e.clus);
                    check("tuser", m_tuser, mon_e.user);
                    check("tlast", m_tlast, mon_e.last);
                    out_count++;
                end
            end
            stalled_prev = m_tvalid && !m_tready;
            held_ctl  = {m_tuser, m_tlast, m_tnumber, m_tcount};
            held_clus = m_tclus;
        end
    end

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel);
        wb_adr = a; wb_dat = d; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        #1;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        wb_adr = a; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1;
        @(negedge clk);
        d = wb_dat_o;
        check("wb_ack", wb_ack, 1'b1);
        @(posedge clk);
        #1;
        wb_stb = 1'b0;
    endtask

    task automatic set_kern(input int k, input logic [15:0] v);
        wb_write(8'(16 + k), {16'h0, v}, 4'hF);
        m_kern[k] = v;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic u, input logic l);
        int n;
        if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) check("in_timeout", 1, 0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int mode);
        int n;
        for (int i = 0; i < X*Y; i++)
            pix[i] = (mode == 0) ? 0 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
        for (int by = 0; by < YB; by++)
            for (int bx = 0; bx < XB; bx++)
                exp_q.push_back(model_block(by, bx));
        out_count = 0;
        for (int yy = 0; yy < Y; yy++)
            for (int xx = 0; xx < X; xx++)
                send_pixel(8'(pix[yy*X + xx]), (xx == 0 && yy == 0), (xx == X-1));
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain", exp_q.size(), 0);
        check("frame_count", out_count, XB*YB);
    endtask

    logic [31:0] rd;
    logic [7:0]  th_r;
    int          wait_n;

    initial begin
        for (int k = 0; k < 10; k++) m_kern[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_ctl", {m_tuser, m_tlast, m_tnumber, m_tcount}, 0);
        check("rst_clus", m_tclus, 0);
        check("rst_tready", s_tready, 1'b1);
        check("rst_ack", wb_ack, 1'b0);
        wb_read(8'h00, rd); check("rd_th", rd, RB ? 32'h7F : 32'h0);
        wb_read(8'h01, rd); check("rd_inv", rd, 0);
        wb_read(8'h13, rd); check("rd_kern", rd, 0);

        wb_write(8'h00, 32'h0000_5500, 4'b0010);
        wb_read(8'h00, rd); check("th_sel_ignored", rd, RB ? 32'h7F : 32'h0);
        wb_write(8'h05, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h05, rd); check("unmapped", rd, 0);

        send_frame(0);

        set_kern(0, 16'hFFFF);
        send_frame(1);

        wb_write(8'h01, 32'h1, 4'h1);
        m_inv = 1'b1;
        wb_read(8'h01, rd); check("rd_inv1", rd, RB ? 32'h1 : 32'h0);
        send_frame(1);

        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 10; k++) set_kern(k, 16'($urandom));
            th_r = 8'($urandom_range(60, 190));
            wb_write(8'h00, {24'h0, th_r}, 4'h1);
            m_th = th_r;
            m_inv = 1'($urandom_range(0, 1));
            wb_write(8'h01, {31'h0, m_inv}, 4'h1);
            wb_read(8'h10, rd); check("rd_kern0", rd, RB ? {16'h0, m_kern[0]} : 32'h0);
            send_frame(2);
        end

        fork
            send_frame(2);
            begin
                bp_hold = 1'b1;
                wait_n = 0;
                while (!m_tvalid && wait_n < 3000) begin
                    wait_n++;
                    @(posedge clk);
                end
                check("bp_first_block", m_tvalid, 1'b1);
                repeat (50) @(posedge clk);
                @(negedge clk);
                check("bp_tready_low", s_tready, 1'b0);
                check("bp_tvalid_held", m_tvalid, 1'b1);
                @(posedge clk);
                #1;
                bp_hold = 1'b0;
            end
        join

        repeat (20) @(posedge clk);
        #1;
        check("idle_tvalid", m_tvalid, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
